// File: rtl/config_bank_axil.sv
// config_bank_axil: AXI4-Lite slave front-end for a banked configuration space.
//
// Writes are decoded into NUM_REGIONS independent config channels, each with a
// local register index, raw write data and byte strobes. Reads are forwarded to
// the owning region as a one-cycle request, and the region answers with a
// one-cycle response. A response that does not arrive within RD_TIMEOUT cycles
// completes the read with SLVERR. Out-of-range accesses complete with SLVERR.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   s_axil_aw*/w*/b*             AXI4-Lite write address, data and response
//   s_axil_ar*/r*                AXI4-Lite read address and data
//   cfg_valid/addr/data/strb     per-region write pulse with its payload
//   rd_req_valid/addr            per-region read request pulse with local index
//   rd_resp_valid/data           per-region read response from the region
module config_bank_axil #(
    parameter int DATA_BITS   = 64,
    parameter int ADDR_BITS   = 64,
    parameter int NUM_REGIONS = 4,
    parameter int REGION_REGS = 16,
    parameter int PIPE_LEVELS = 1,
    parameter int RD_TIMEOUT  = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_axil_awvalid,
    output logic                               s_axil_awready,
    input  logic [ADDR_BITS-1:0]               s_axil_awaddr,
    input  logic                               s_axil_wvalid,
    output logic                               s_axil_wready,
    input  logic [DATA_BITS-1:0]               s_axil_wdata,
    input  logic [DATA_BITS/8-1:0]             s_axil_wstrb,
    output logic                               s_axil_bvalid,
    input  logic                               s_axil_bready,
    output logic [1:0]                         s_axil_bresp,
    input  logic                               s_axil_arvalid,
    output logic                               s_axil_arready,
    input  logic [ADDR_BITS-1:0]               s_axil_araddr,
    output logic                               s_axil_rvalid,
    input  logic                               s_axil_rready,
    output logic [DATA_BITS-1:0]               s_axil_rdata,
    output logic [1:0]                         s_axil_rresp,
    output logic [NUM_REGIONS-1:0]             cfg_valid,
    output logic [NUM_REGIONS*$clog2(REGION_REGS)-1:0] cfg_addr,
    output logic [NUM_REGIONS*DATA_BITS-1:0]   cfg_data,
    output logic [NUM_REGIONS*DATA_BITS/8-1:0] cfg_strb,
    output logic [NUM_REGIONS-1:0]             rd_req_valid,
    output logic [NUM_REGIONS*$clog2(REGION_REGS)-1:0] rd_req_addr,
    input  logic [NUM_REGIONS-1:0]             rd_resp_valid,
    input  logic [NUM_REGIONS*DATA_BITS-1:0]   rd_resp_data
);
    localparam int ADDR_LSB  = $clog2(DATA_BITS/8);
    localparam int LOC_BITS  = $clog2(REGION_REGS);
    localparam int IDX_BITS  = $clog2(NUM_REGIONS*REGION_REGS);
    localparam int STRB_BITS = DATA_BITS/8;
    localparam int HI_LSB    = ADDR_LSB + IDX_BITS;
    localparam int CNT_BITS  = $clog2(RD_TIMEOUT+1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // ---------------- address decode ----------------
    logic [IDX_BITS-1:0] aw_idx, aw_region, ar_idx, ar_region;
    logic [LOC_BITS-1:0] aw_local, ar_local;
    logic                aw_ok, ar_ok;

    assign aw_idx    = s_axil_awaddr[ADDR_LSB +: IDX_BITS];
    assign ar_idx    = s_axil_araddr[ADDR_LSB +: IDX_BITS];
    assign aw_region = aw_idx >> LOC_BITS;
    assign ar_region = ar_idx >> LOC_BITS;
    assign aw_local  = aw_idx[LOC_BITS-1:0];
    assign ar_local  = ar_idx[LOC_BITS-1:0];
    // The region compare only matters when NUM_REGIONS is not a power of two.
    assign aw_ok = ((s_axil_awaddr >> HI_LSB) == '0) && (aw_region < IDX_BITS'(NUM_REGIONS));
    assign ar_ok = ((s_axil_araddr >> HI_LSB) == '0) && (ar_region < IDX_BITS'(NUM_REGIONS));

    // Byte-offset bits carry no meaning in a register-granular map.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, s_axil_awaddr[ADDR_LSB-1:0], s_axil_araddr[ADDR_LSB-1:0]};

    // ---------------- write FSM ----------------
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    w_state_t   w_state_reg, w_state_next;
    logic [1:0] bresp_reg, bresp_next;
    logic       w_hs, w_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_reg <= W_IDLE;
            bresp_reg   <= RESP_OKAY;
        end else begin
            w_state_reg <= w_state_next;
            bresp_reg   <= bresp_next;
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        bresp_next   = bresp_reg;
        w_hs         = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                // Address and data are only ever accepted together.
                if (s_axil_awvalid && s_axil_wvalid) begin
                    w_hs         = 1'b1;
                    w_state_next = W_RESP;
                    bresp_next   = aw_ok ? RESP_OKAY : RESP_SLVERR;
                end
            end
            W_RESP:  if (s_axil_bready) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    assign s_axil_awready = w_hs && !rst;
    assign s_axil_wready  = w_hs && !rst;
    assign s_axil_bvalid  = (w_state_reg == W_RESP);
    assign s_axil_bresp   = bresp_reg;
    assign w_pulse        = w_hs && aw_ok && (|s_axil_wstrb);

    // ---------------- read FSM ----------------
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    r_state_t             r_state_reg, r_state_next;
    logic [IDX_BITS-1:0]  rd_region_reg, rd_region_next;
    logic [CNT_BITS-1:0]  cnt_reg, cnt_next;
    logic [DATA_BITS-1:0] rdata_reg, rdata_next, resp_data;
    logic [1:0]           rresp_reg, rresp_next;
    logic [NUM_REGIONS-1:0] resp_hit;
    logic                 r_hs, r_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_reg   <= R_IDLE;
            rd_region_reg <= '0;
            cnt_reg       <= '0;
            rdata_reg     <= '0;
            rresp_reg     <= RESP_OKAY;
        end else begin
            r_state_reg   <= r_state_next;
            rd_region_reg <= rd_region_next;
            cnt_reg       <= cnt_next;
            rdata_reg     <= rdata_next;
            rresp_reg     <= rresp_next;
        end
    end

    // Only the region that owns the outstanding read may complete it.
    always_comb begin
        resp_data = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (resp_hit[r]) resp_data = rd_resp_data[r*DATA_BITS +: DATA_BITS];
        end
    end

    always_comb begin
        r_state_next   = r_state_reg;
        rd_region_next = rd_region_reg;
        cnt_next       = cnt_reg;
        rdata_next     = rdata_reg;
        rresp_next     = rresp_reg;
        r_hs           = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                if (s_axil_arvalid) begin
                    r_hs           = 1'b1;
                    rd_region_next = ar_region;
                    cnt_next       = '0;
                    if (ar_ok) begin
                        r_state_next = R_WAIT;
                    end else begin
                        r_state_next = R_RESP;
                        rresp_next   = RESP_SLVERR;
                        rdata_next   = '0;
                    end
                end
            end
            R_WAIT: begin
                // A response in the timeout cycle still wins.
                if (|resp_hit) begin
                    rdata_next   = resp_data;
                    rresp_next   = RESP_OKAY;
                    r_state_next = R_RESP;
                end else if (cnt_reg == CNT_BITS'(RD_TIMEOUT-1)) begin
                    rdata_next   = '0;
                    rresp_next   = RESP_SLVERR;
                    r_state_next = R_RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            R_RESP:  if (s_axil_rready) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    assign s_axil_arready = (r_state_reg == R_IDLE) && !rst;
    assign s_axil_rvalid  = (r_state_reg == R_RESP);
    assign s_axil_rdata   = rdata_reg;
    assign s_axil_rresp   = rresp_reg;
    assign r_pulse        = r_hs && ar_ok;

    // ---------------- per-region selects ----------------
    logic [NUM_REGIONS-1:0] w_sel, r_sel;
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            assign w_sel[gi]    = w_pulse && (aw_region == IDX_BITS'(gi));
            assign r_sel[gi]    = r_pulse && (ar_region == IDX_BITS'(gi));
            assign resp_hit[gi] = rd_resp_valid[gi] && (r_state_reg == R_WAIT)
                                  && (rd_region_reg == IDX_BITS'(gi));
        end
    endgenerate

    // ---------------- outgoing pipelines ----------------
    // Stage 0 is loaded at the handshake edge; stages 1..PIPE_LEVELS only add
    // delay so the channel can be floorplanned across an SLR boundary.
    logic [NUM_REGIONS-1:0]           wp_vld_reg  [0:PIPE_LEVELS];
    logic [NUM_REGIONS*LOC_BITS-1:0]  wp_addr_reg [0:PIPE_LEVELS];
    logic [NUM_REGIONS*DATA_BITS-1:0] wp_data_reg [0:PIPE_LEVELS];
    logic [NUM_REGIONS*STRB_BITS-1:0] wp_strb_reg [0:PIPE_LEVELS];
    logic [NUM_REGIONS-1:0]           rp_vld_reg  [0:PIPE_LEVELS];
    logic [NUM_REGIONS*LOC_BITS-1:0]  rp_addr_reg [0:PIPE_LEVELS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s <= PIPE_LEVELS; s++) begin
                wp_vld_reg[s]  <= '0;
                wp_addr_reg[s] <= '0;
                wp_data_reg[s] <= '0;
                wp_strb_reg[s] <= '0;
                rp_vld_reg[s]  <= '0;
                rp_addr_reg[s] <= '0;
            end
        end else begin
            wp_vld_reg[0] <= w_sel;
            rp_vld_reg[0] <= r_sel;
            for (int r = 0; r < NUM_REGIONS; r++) begin
                if (w_sel[r]) begin
                    wp_addr_reg[0][r*LOC_BITS +: LOC_BITS]   <= aw_local;
                    wp_data_reg[0][r*DATA_BITS +: DATA_BITS] <= s_axil_wdata;
                    wp_strb_reg[0][r*STRB_BITS +: STRB_BITS] <= s_axil_wstrb;
                end
                if (r_sel[r]) rp_addr_reg[0][r*LOC_BITS +: LOC_BITS] <= ar_local;
            end
            for (int s = 1; s <= PIPE_LEVELS; s++) begin
                wp_vld_reg[s]  <= wp_vld_reg[s-1];
                wp_addr_reg[s] <= wp_addr_reg[s-1];
                wp_data_reg[s] <= wp_data_reg[s-1];
                wp_strb_reg[s] <= wp_strb_reg[s-1];
                rp_vld_reg[s]  <= rp_vld_reg[s-1];
                rp_addr_reg[s] <= rp_addr_reg[s-1];
            end
        end
    end

    assign cfg_valid    = wp_vld_reg[PIPE_LEVELS];
    assign cfg_addr     = wp_addr_reg[PIPE_LEVELS];
    assign cfg_data     = wp_data_reg[PIPE_LEVELS];
    assign cfg_strb     = wp_strb_reg[PIPE_LEVELS];
    assign rd_req_valid = rp_vld_reg[PIPE_LEVELS];
    assign rd_req_addr  = rp_addr_reg[PIPE_LEVELS];

endmodule
